// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment counter.
//
// Contents:
//   nibble_t    - one displayed digit (4 bits, hex or BCD)
//   SEG_A/SEG_G - bit positions of segments a and g in a segment word
//   SEG_W       - width of a segment word (a..g)
//   SEG_TABLE   - active-high segment patterns for nibbles 0..F
//   encode()    - nibble -> segment word lookup
package seven_seg_pkg;

    typedef logic [3:0] nibble_t;

    // Segment word layout: bit6..0 = g,f,e,d,c,b,a.
    localparam int SEG_A = 0;
    localparam int SEG_G = 6;
    localparam int SEG_W = SEG_G - SEG_A + 1;

    // Entry 15 (F) first so that SEG_TABLE[n] is the pattern for nibble n.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [SEG_W-1:0] encode(input nibble_t n);
        return SEG_TABLE[n];
    endfunction

endpackage

// File: rtl/seven_seg_digit_counter.sv
// One digit of the ripple up/down counter.
//
// Ports:
//   clock, reset - system clock, synchronous active-high reset
//   up           - 1 = count up, 0 = count down
//   bcd          - 1 = decimal digit (0-9), 0 = hex digit (0-F)
//   carryIn      - step request from the digit below (or the prescaler)
//   load         - parallel load strobe, beats carryIn
//   loadNibble   - value taken on load (not range-checked)
//   value        - current digit contents
//   carryOut     - carry (up) or borrow (down) into the next digit
module seven_seg_digit_counter
    import seven_seg_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    up,
    input  logic    bcd,
    input  logic    carryIn,
    input  logic    load,
    input  nibble_t loadNibble,
    output nibble_t value,
    output logic    carryOut
);

    nibble_t value_q;
    nibble_t value_d;
    logic    at_top;

    always_comb begin
        // In BCD mode anything >= 9 (including stray A-F) rolls over to 0 with a carry.
        at_top   = bcd ? (value_q >= 4'd9) : (value_q == 4'hF);
        value_d  = value_q;
        carryOut = 1'b0;
        if (load) begin
            value_d = loadNibble;
        end else if (carryIn) begin
            if (up) begin
                if (at_top) begin
                    value_d  = 4'd0;
                    carryOut = 1'b1;
                end else begin
                    value_d = value_q + 4'd1;
                end
            end else if (value_q == 4'd0) begin
                value_d  = bcd ? 4'd9 : 4'hF;
                carryOut = 1'b1;
            end else if (bcd && (value_q > 4'd9)) begin
                // Stray A-F in BCD mode drops to 9 without borrowing.
                value_d = 4'd9;
            end else begin
                value_d = value_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/seven_seg_mux_counter.sv
// N-digit up/down hex/BCD counter with parallel load, leading-zero
// blanking and a time-multiplexed seven-segment driver.
//
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   io_en         - count enable (freezes prescaler and counter when 0)
//   io_up         - 1 = count up, 0 = count down
//   io_bcd        - 1 = decimal digits, 0 = hex digits
//   io_blank      - blank leading zero digits (digit 0 never blanked)
//   io_load       - parallel load strobe, io_loadValue nibble i -> digit i
//   io_seg        - registered segments g..a, active-high
//   io_digitSel   - registered one-hot digit enable
//   io_tick       - registered one-cycle pulse on each count step
//   io_value      - counter contents
module seven_seg_mux_counter
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 10000000,
    parameter int REFRESH_DIV = 1000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    io_en,
    input  logic                    io_up,
    input  logic                    io_bcd,
    input  logic                    io_blank,
    input  logic                    io_load,
    input  logic [4*NUM_DIGITS-1:0] io_loadValue,
    output logic [SEG_W-1:0]        io_seg,
    output logic [NUM_DIGITS-1:0]   io_digitSel,
    output logic                    io_tick,
    output logic [4*NUM_DIGITS-1:0] io_value
);

    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int REF_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // ---------------- prescaler ----------------
    logic [TICK_W-1:0] presc_q, presc_d;
    logic              tick_q, tick_d;
    logic              step;

    always_comb begin
        presc_d = presc_q;
        step    = 1'b0;
        tick_d  = 1'b0;
        if (io_load) begin
            // Load restarts the tick period and swallows a coincident step.
            presc_d = '0;
        end else if (io_en) begin
            if (presc_q == TICK_W'(TICK_DIV - 1)) begin
                presc_d = '0;
                step    = 1'b1;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + TICK_W'(1);
            end
        end
    end

    // ---------------- digit carry chain ----------------
    logic [NUM_DIGITS:0] carry_chain;
    logic [VAL_W-1:0]    value;
    logic                wrap_carry_unused;

    assign carry_chain[0] = step;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seven_seg_digit_counter u_digit (
            .clock      (clock),
            .reset      (reset),
            .up         (io_up),
            .bcd        (io_bcd),
            .carryIn    (carry_chain[i]),
            .load       (io_load),
            .loadNibble (io_loadValue[4*i +: 4]),
            .value      (value[4*i +: 4]),
            .carryOut   (carry_chain[i+1])
        );
    end

    // Carry out of the top digit is a full wrap and is simply dropped.
    assign wrap_carry_unused = carry_chain[NUM_DIGITS];

    // ---------------- display multiplexing ----------------
    logic [REF_W-1:0]      refresh_q, refresh_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [VAL_W-1:0]      upper;
    logic                  blank;

    always_comb begin
        refresh_d = refresh_q + REF_W'(1);
        idx_d     = idx_q;
        if (refresh_q == REF_W'(REFRESH_DIV - 1)) begin
            refresh_d = '0;
            idx_d     = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // Selected digit and everything above it, shifted down to bit 0.
        upper = value >> {idx_q, 2'b00};
        blank = io_blank && (idx_q != '0) && (upper == '0);
        seg_d = blank ? '0 : encode(value[{idx_q, 2'b00} +: 4]);
        sel_d = NUM_DIGITS'(1) << idx_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            refresh_q <= '0;
            idx_q     <= '0;
            seg_q     <= '0;
            sel_q     <= '0;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            refresh_q <= refresh_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            sel_q     <= sel_d;
        end
    end

    assign io_seg      = seg_q;
    assign io_digitSel = sel_q;
    assign io_tick     = tick_q;
    assign io_value    = value;

endmodule

// File: doc/seven_seg_mux_counter.md
Name: seven_seg_mux_counter

Overview:
- Parametrised successor to the single-digit seconds display: an N-digit up/down counter with runtime hex/BCD mode, parallel load, leading-zero blanking and a time-multiplexed seven-segment driver.
- Sits under the TinyTapeout top wrapper; switches drive the control inputs, and segment/digit-select lines drive uo_out/uio_out.
- All outputs are registered.

Parameters:
- NUM_DIGITS, 4, number of displayed digits/nibbles (1..8)
- TICK_DIV, 10000000, clock cycles per count tick (1 s at 10 MHz; must be >= 1)
- REFRESH_DIV, 1000, clock cycles each digit stays selected (>= 1)

Ports:
- clock  in  1  single system clock
- reset  in  1  synchronous, active-high reset
- io_en  in  1  count enable; 0 freezes the prescaler and the counter
- io_up  in  1  1 = count up, 0 = count down
- io_bcd  in  1  1 = decimal digits 0-9, 0 = hex digits 0-F
- io_blank  in  1  1 = blank leading zero digits (digit 0 is never blanked)
- io_load  in  1  synchronous parallel load strobe
- io_loadValue  in  4*NUM_DIGITS  value to load, nibble i = digit i
- io_seg  out  7  segments, active-high, bit6..0 = g,f,e,d,c,b,a
- io_digitSel  out  NUM_DIGITS  one-hot active-high digit enable
- io_tick  out  1  one-cycle pulse on each count step
- io_value  out  4*NUM_DIGITS  current counter contents

Behaviour:
- Reset (synchronous, active-high):
  - Prescaler, counter and refresh counter go to 0; digit index goes to 0.
  - io_seg = 0, io_digitSel = 0, io_tick = 0, io_value = 0.
  - Reset beats every other input and may be asserted mid-count or mid-refresh.
- Prescaler:
  - When io_en = 1, it counts 0..TICK_DIV-1 and wraps to 0.
  - The cycle on which it wraps is a step cycle.
  - When io_en = 0, it holds its value.
  - TICK_DIV = 1 means every enabled cycle is a step.
- Step:
  - The counter changes by ±1 and io_tick = 1 on the next cycle; io_value updates in that same cycle.
- Count arithmetic is per digit, with a ripple carry/borrow from digit 0 upward:
  - Hex mode: digit range 0-F.
  - BCD mode: up from 9 gives 0 plus a carry; down from 0 gives 9 plus a borrow.
  - BCD mode, digit holding A-F (left over from hex mode or from a load): an up step sets it to 0 with a carry; a down step sets it to 9 with no borrow.
  - Full wrap: all-max up goes to all-zero; all-zero down goes to all-max (0x..F or 9..9 per mode).
- Load:
  - When io_load = 1, the counter takes io_loadValue on the next edge and the prescaler clears to 0.
  - Load has priority over a simultaneous step; io_tick stays 0 that cycle.
  - Loaded digits are not range-checked.
- Mode change (io_bcd toggled) takes effect at the next step; no conversion is done.
- Display multiplexing:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously; io_en does not affect it.
  - On wrap, the digit index advances (NUM_DIGITS-1 wraps to 0).
  - io_digitSel = one-hot(index) and io_seg = encode(digit[index]), both registered, so they reflect the index and counter one cycle later.
  - The first non-zero io_digitSel appears on the 1st cycle after reset deasserts.
- Encoding (a..g):
  - 0 = 0x3F, 1 = 0x06, 2 = 0x5B, 3 = 0x4F, 4 = 0x66, 5 = 0x6D, 6 = 0x7D, 7 = 0x07, 8 = 0x7F, 9 = 0x6F.
  - A = 0x77, b = 0x7C, C = 0x39, d = 0x5E, E = 0x79, F = 0x71.
- Blanking:
  - When io_blank = 1 and digit i together with every higher digit is zero (and i > 0), io_seg = 0 while digit i is selected.
  - io_digitSel is still driven in that case.

Decomposition:
- Shared package seven_seg_pkg holds:
  - the 16-entry segment encoding constant table and segment bit-index constants;
  - the digit nibble typedef (4 bits);
  - the function encode(nibble) -> 7 bits.
- One natural sub-module, seven_seg_digit_counter: a single digit with inputs up, bcd, carryIn, load, loadNibble and outputs value, carryOut. It is instantiated NUM_DIGITS times in a carry chain.

Test Plan:
- Use TICK_DIV = 4, REFRESH_DIV = 2, NUM_DIGITS = 4 unless stated otherwise.
- Reset and enable: reset 3 cycles, then io_en = 1, up, hex for 16 cycles -> io_tick pulses every 4th cycle; io_value steps 0x0000..0x0004; io_seg = 0 and io_digitSel = 0 during reset.
- BCD carry: load 0x0099, bcd, up, one step -> io_value = 0x0100. Load 0x9999, one step -> 0x0000. Hex mode, load 0xFFFF, one step -> 0x0000.
- Down/borrow: load 0x0100, bcd, down, one step -> 0x0099. Load 0x0000, down, hex -> 0xFFFF; in bcd -> 0x9999. Load 0x000C, bcd, down -> 0x0009 with no borrow.
- Load/step collision: assert io_load with value 0x1234 on a step cycle -> io_value = 0x1234, io_tick = 0, and the next step arrives exactly 4 cycles later -> 0x1235.
- Multiplex and blanking: hold the value 0x0007 with io_en = 0 and io_blank = 1 -> io_digitSel cycles 0001, 0010, 0100, 1000, changing every 2 cycles; io_seg = 0x07 with digit 0 selected and 0x00 with digits 1-3 selected. With io_blank = 0, digits 1-3 show 0x3F.
- Reset mid-operation: assert reset while the counter = 0x0042 and digit index = 2 -> the next cycle shows all outputs 0; after release, counting resumes from 0x0000 with the prescaler starting at 0.
